// File: rtl/pwm_pkg.sv
// pwm_pkg -- definitions shared by the PWM generator and the PWM capture block.
//
// Contents:
//   pwm_state_e        capture FSM state encoding (IDLE, HIGH, LOW)
//   PWM_*_DEF          default parameter values (50 MHz system clock)
//   PWM_SERVO_MIN/MAX  servo pulse limits in clk cycles (1 ms / 2 ms at 50 MHz)
//   pwm_cnt_width()    bits needed to hold a count from 0 to n inclusive
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a first rise to arm the measurement
    HIGH = 2'd1,  // input high, counting high time
    LOW  = 2'd2   // input low, waiting for the rise that closes the period
  } pwm_state_e;

  localparam int unsigned PWM_W_DEF          = 32;
  localparam int unsigned PWM_TIMEOUT_DEF    = 2000000;  // 40 ms at 50 MHz
  localparam int unsigned PWM_FILTER_LEN_DEF = 4;
  localparam int unsigned PWM_SERVO_MIN      = 50000;    // 1 ms at 50 MHz
  localparam int unsigned PWM_SERVO_MAX      = 100000;   // 2 ms at 50 MHz

  function automatic int unsigned pwm_cnt_width(input int unsigned n);
    int unsigned bits;
    bits = $clog2(n + 1);
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/pwm_sync_filter.sv
// pwm_sync_filter -- brings the asynchronous PWM pin into the clk domain and
// produces a clean level for edge detection.
//
// Build option: define PWM_GLITCH_FILTER_EN to add a glitch filter after the
// synchronizer. The filtered level only follows the synchronized input once
// it has held a new value for FILTER_LEN consecutive cycles, so both edges are
// delayed by the same FILTER_LEN cycles and shorter pulses are dropped.
// Without the macro the synchronized level is passed straight through.
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   d_i     raw asynchronous PWM input
//   q_o     synchronized (and optionally filtered) level
module pwm_sync_filter
  import pwm_pkg::*;
#(
  parameter int unsigned FILTER_LEN = PWM_FILTER_LEN_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (FILTER_LEN == 0) begin : g_len_check
    $error("pwm_sync_filter: FILTER_LEN must be at least 1");
  end

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  localparam int unsigned FCW = pwm_cnt_width(FILTER_LEN);
  localparam logic [FCW-1:0] FLAST = FCW'(FILTER_LEN - 1);

  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  // fcnt counts consecutive cycles in which the input disagrees with the
  // filtered level; any agreeing cycle restarts the count.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FLAST) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign q_o = filt_q;
`else
  assign q_o = sync2_q;
`endif

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture -- measures an incoming PWM/servo pulse train.
//
// Once per completed period (rise to rise) the high time and the period are
// reported in clk cycles with a one-cycle valid strobe, three clocks after
// the pin rise that closes the period (two sync stages + edge register).
// If no edge arrives within TIMEOUT cycles of the last rise the sticky timeout
// flag is raised; it clears on the next valid measurement. Measurements hold
// their last values through timeout and are only cleared by reset.
//
// Build option: PWM_GLITCH_FILTER_EN enables the glitch filter inside
// pwm_sync_filter (FILTER_LEN stable cycles per edge).
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   pwm_in   asynchronous PWM input pin
//   width    last measured high time, cycles
//   period   last measured rise-to-rise period, cycles
//   valid    one-cycle strobe: width/period updated this cycle
//   timeout  sticky loss-of-signal flag
//   ledres   status LED: timeout, forced on while reset is asserted
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned W          = PWM_W_DEF,
  parameter int unsigned TIMEOUT    = PWM_TIMEOUT_DEF,
  parameter int unsigned FILTER_LEN = PWM_FILTER_LEN_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [W-1:0] width,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         timeout,
  output logic         ledres
);

  if ((64'(TIMEOUT) + 64'd1) >= (64'd1 << W)) begin : g_timeout_check
    $error("pwm_capture: TIMEOUT must be below 2^W-1");
  end

  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);
  localparam logic [W-1:0] ONE       = W'(1);

  logic s;
  logic s_prev_q;
  logic rise;
  logic fall;
  logic at_limit;

  pwm_state_e   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] hi_lat_q, hi_lat_d;
  logic [W-1:0] width_q, width_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;

  pwm_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (pwm_in),
    .q_o    (s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_prev_q <= 1'b0;
    end else begin
      s_prev_q <= s;
    end
  end

  assign rise     = s & ~s_prev_q;
  assign fall     = ~s & s_prev_q;
  assign at_limit = (cnt_q == TIMEOUT_W);

  // Edges are tested before the limit in every state, so an edge arriving in
  // the same cycle as the limit is measured and no timeout is raised.
  // IDLE never times out: loss of signal is only judged after a first rise.
  always_comb begin
    state_d   = state_q;
    hi_lat_d  = hi_lat_q;
    width_d   = width_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (rise) begin
      cnt_d = ONE;
    end else if (at_limit) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = HIGH;
          cnt_d   = ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d  = LOW;
          hi_lat_d = cnt_q;
        end else if (at_limit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end
      end
      LOW: begin
        if (rise) begin
          state_d   = HIGH;
          period_d  = cnt_q;
          width_d   = hi_lat_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
        end else if (at_limit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_lat_q  <= '0;
      width_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_lat_q  <= hi_lat_d;
      width_q   <= width_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign width   = width_q;
  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign ledres  = timeout_q | ~reset;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture -- scoreboard bench for pwm_capture (W=16, TIMEOUT=1000,
// FILTER_LEN=4). The stimulus is a list of pin segments (level, length); a
// reference model derives the expected measurements from segment boundaries
// and pushes them into a queue that a monitor drains on every valid strobe.
module tb_pwm_capture;

  localparam int unsigned W          = 16;
  localparam int unsigned TIMEOUT    = 1000;
  localparam int unsigned FILTER_LEN = 4;
`ifdef PWM_GLITCH_FILTER_EN
  localparam int MINSEG = FILTER_LEN + 1;
`else
  localparam int MINSEG = 1;
`endif
  // cycles an observable event needs before steady-state checks are made
  localparam int GATE = 12;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         pin   = 1'b0;
  logic [W-1:0] width;
  logic [W-1:0] period;
  logic         valid;
  logic         timeout;
  logic         ledres;

  pwm_capture #(
    .W          (W),
    .TIMEOUT    (TIMEOUT),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .pwm_in  (pin),
    .width   (width),
    .period  (period),
    .valid   (valid),
    .timeout (timeout),
    .ledres  (ledres)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int p;
  } meas_t;

  meas_t sbq[$];
  meas_t mon_m;
  int    vectors     = 0;
  int    miscompares = 0;

  // reference model state, all in pin-time cycles
  int t;          // cycles driven since start
  bit cur;        // level the block last saw
  int armed;      // 0: not armed, 1: in high phase, 2: in low phase
  int rise_t;
  int fall_t;
  bit to_flag;
  int last_w;
  int last_p;
  int last_evt;   // time of the last change visible on the outputs

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: actual %0d, expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  // More than TIMEOUT cycles since the last rise without a new rise is loss
  // of signal; an edge at exactly TIMEOUT cycles still counts.
  function automatic void model_timeout(input int now);
    if (armed != 0 && now - rise_t > TIMEOUT) begin
      armed    = 0;
      to_flag  = 1'b1;
      last_evt = rise_t + TIMEOUT;
    end
  endfunction

  function automatic void model_edge(input bit lvl);
    model_timeout(t);
    if (lvl != cur) begin
      if (lvl) begin
        if (armed == 2) begin
          last_w = fall_t - rise_t;
          last_p = t - rise_t;
          sbq.push_back('{last_w, last_p});
          to_flag  = 1'b0;
          last_evt = t;
        end
        armed  = 1;
        rise_t = t;
      end else if (armed == 1) begin
        armed  = 2;
        fall_t = t;
      end
      cur = lvl;
    end
  endfunction

  task automatic sample();
    model_timeout(t);
    if (t - last_evt >= GATE) begin
      check("timeout", timeout, to_flag);
      check("ledres", ledres, to_flag);
      check("width_hold", width, last_w);
      check("period_hold", period, last_p);
    end
  endtask

  task automatic seg(input bit lvl, input int len);
    model_edge(lvl);
    pin = lvl;
    repeat (len) @(negedge clk);
    t += len;
    sample();
  endtask

  // short pulse: a real edge pair without the filter, invisible with it
  task automatic glitch(input bit lvl, input int len);
`ifdef PWM_GLITCH_FILTER_EN
    pin = lvl;
    repeat (len) @(negedge clk);
    t += len;
`else
    seg(lvl, len);
`endif
  endtask

  task automatic do_reset();
    check("queue_empty_at_reset", sbq.size(), 0);
    sbq.delete();
    rst_n = 1'b0;
    #1;
    check("rst_width", width, 0);
    check("rst_period", period, 0);
    check("rst_valid", valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_ledres", ledres, 1);
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    t       += 3;
    cur      = 1'b0;
    armed    = 0;
    to_flag  = 1'b0;
    last_w   = 0;
    last_p   = 0;
    last_evt = t - GATE;
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: actual width=%0d period=%0d, expected no strobe", width, period);
      end else begin
        mon_m = sbq.pop_front();
        check("valid_width", width, mon_m.w);
        check("valid_period", period, mon_m.p);
        check("valid_timeout_clear", timeout, 0);
      end
    end
  end

  initial begin
    t        = 0;
    cur      = 1'b0;
    armed    = 0;
    rise_t   = 0;
    fall_t   = 0;
    to_flag  = 1'b0;
    last_w   = 0;
    last_p   = 0;
    last_evt = -100000;

    @(negedge clk);
    do_reset();

    // idle low just short of TIMEOUT: nothing reported
    seg(1'b0, 999);

    // steady 30/70: first rise only arms
    repeat (4) begin
      seg(1'b1, 30);
      seg(1'b0, 70);
    end

    // tempo change mid-stream
    repeat (3) begin
      seg(1'b1, 150);
      seg(1'b0, 50);
    end

    // random duty and period, well inside TIMEOUT
    for (int i = 0; i < 25; i++) begin
      seg(1'b1, int'($urandom_range(300, MINSEG)));
      seg(1'b0, int'($urandom_range(300, MINSEG)));
    end

    // stuck high, then recovery
    seg(1'b1, 1200);
    seg(1'b0, 50);
    seg(1'b1, 30);
    seg(1'b0, 70);
    seg(1'b1, 30);
    seg(1'b0, 70);

    // period exactly TIMEOUT is measured, TIMEOUT+1 is loss of signal
    seg(1'b1, 30);
    seg(1'b0, TIMEOUT - 30);
    seg(1'b1, 30);
    seg(1'b0, TIMEOUT - 29);
    seg(1'b1, 30);
    seg(1'b0, 70);
    seg(1'b1, 30);
    seg(1'b0, 70);

    // stuck low, then recovery
    seg(1'b1, 30);
    seg(1'b0, 1200);
    seg(1'b1, 30);
    seg(1'b0, 70);
    seg(1'b1, 30);
    seg(1'b0, 70);

    // 2-cycle glitches inside a 30/70 stream
    repeat (3) begin
      seg(1'b1, 10);
      glitch(1'b0, 2);
      seg(1'b1, 18);
      seg(1'b0, 35);
      glitch(1'b1, 2);
      seg(1'b0, 33);
    end
    seg(1'b1, 30);
    seg(1'b0, 70);

    // reset in the middle of a high phase
    seg(1'b1, 30);
    seg(1'b0, 70);
    seg(1'b1, 15);
    do_reset();
    seg(1'b1, 15);
    seg(1'b0, 70);
    seg(1'b1, 30);
    seg(1'b0, 70);
    seg(1'b1, 30);
    seg(1'b0, 40);

    check("pending_measurements", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
